// File: rtl/stage_sequencer_if.sv
// Bus bundle for stage_sequencer, plus the shared stage and instruction-type
// encodings used by the sequencer and anything that talks to it.
//
// Protocol: there is no valid/ready pair. The sequencer owns the timing.
// The master holds current_instr_type stable for a whole instruction.
// The sequencer samples mem_read_data only on the edge that leaves
// INSTR_FETCH (instruction word), or the edge that leaves MEMORY (load data).
// It samples branch_taken/branch_target only on the edge that leaves EXECUTE.
// Values presented at any other time are ignored.

`ifndef STAGE_SEQUENCER_DEFINES
`define STAGE_SEQUENCER_DEFINES
`define STAGE_WIDTH        3
`define STAGE_PC_UPDATE    3'd0
`define STAGE_INSTR_FETCH  3'd1
`define STAGE_DECODE       3'd2
`define STAGE_EXECUTE      3'd3
`define STAGE_MEMORY       3'd4
`define STAGE_REG_WRITE    3'd5
`define STAGE_HALTED       3'd6
`define INSTR_ALU          5'd0
`define INSTR_LOAD         5'd1
`define INSTR_STORE        5'd2
`define INSTR_BRANCH       5'd3
`define INSTR_JUMP         5'd4
`define INSTR_HALT         5'd5
`endif

interface stage_sequencer_if;
  logic [4:0]              current_instr_type;
  logic [31:0]             mem_read_data;
  logic                    branch_taken;
  logic [31:0]             branch_target;
  logic [`STAGE_WIDTH-1:0] stage;
  logic [31:0]             PC_value;
  logic [31:0]             instr_reg;
  logic [31:0]             load_data;
  logic                    reg_write_enable;
  logic                    halted;
  logic [31:0]             retired_count;

  modport slave (
    input  current_instr_type, mem_read_data, branch_taken, branch_target,
    output stage, PC_value, instr_reg, load_data, reg_write_enable, halted,
           retired_count
  );

  modport master (
    output current_instr_type, mem_read_data, branch_taken, branch_target,
    input  stage, PC_value, instr_reg, load_data, reg_write_enable, halted,
           retired_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer.
// It walks each instruction through PC_UPDATE, FETCH, DECODE, EXECUTE,
// MEMORY and REG_WRITE, waiting MEM_LATENCY cycles on main-memory stages.
// It captures the instruction word, load data and the branch decision, and
// owns the PC and the retired-instruction counter.
// A HALT instruction parks the FSM in HALTED until reset.
// The stage output is the FSM state itself.

module stage_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  stage_sequencer_if.slave bus
);

  // The wait counter reaches WAIT_LAST on the final cycle of a memory wait.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] WAIT_MAX  = 4'hF;

  typedef enum logic [`STAGE_WIDTH-1:0] {
    S_PC_UPDATE   = `STAGE_PC_UPDATE,
    S_INSTR_FETCH = `STAGE_INSTR_FETCH,
    S_DECODE      = `STAGE_DECODE,
    S_EXECUTE     = `STAGE_EXECUTE,
    S_MEMORY      = `STAGE_MEMORY,
    S_REG_WRITE   = `STAGE_REG_WRITE,
    S_HALTED      = `STAGE_HALTED
  } stage_e;

  stage_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_q, load_d;
  logic [31:0] retired_q, retired_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;

  logic        leaving;
  logic        is_mem_type;
  logic        is_load_type;
  logic        is_halt_type;
  logic        writes_reg;
  logic [3:0]  wait_inc;

  assign is_load_type = (bus.current_instr_type == `INSTR_LOAD);
  assign is_mem_type  = is_load_type || (bus.current_instr_type == `INSTR_STORE);
  assign is_halt_type = (bus.current_instr_type == `INSTR_HALT);
  assign writes_reg   = !((bus.current_instr_type == `INSTR_STORE)  ||
                          (bus.current_instr_type == `INSTR_BRANCH) ||
                          (bus.current_instr_type == `INSTR_JUMP)   ||
                          (bus.current_instr_type == `INSTR_HALT));
  // The wait counter saturates rather than wraps.
  assign wait_inc     = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;
  assign leaving      = (state_d != state_q);

  // Next stage and wait counter; every stage change clears the counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_PC_UPDATE:   state_d = S_INSTR_FETCH;
      S_INSTR_FETCH: begin
        if (wait_q == WAIT_LAST) state_d = S_DECODE;
        else                     wait_d  = wait_inc;
      end
      S_DECODE:      state_d = is_halt_type ? S_HALTED : S_EXECUTE;
      S_EXECUTE:     state_d = S_MEMORY;
      S_MEMORY: begin
        if (!is_mem_type || (wait_q == WAIT_LAST)) state_d = S_REG_WRITE;
        else                                       wait_d  = wait_inc;
      end
      S_REG_WRITE:   state_d = S_PC_UPDATE;
      S_HALTED:      state_d = S_HALTED;
      default:       state_d = S_PC_UPDATE;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  // Stage register and wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PC_UPDATE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Datapath next values: each capture happens only on its stage's exit edge.
  always_comb begin
    instr_d     = instr_q;
    load_d      = load_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    if ((state_q == S_INSTR_FETCH) && leaving) instr_d = bus.mem_read_data;
    if ((state_q == S_MEMORY) && leaving && is_load_type) load_d = bus.mem_read_data;
    if (state_q == S_EXECUTE) begin
      br_taken_d  = bus.branch_taken;
      br_target_d = bus.branch_target;
    end
    if (state_q == S_REG_WRITE) begin
      pc_d      = br_taken_q ? br_target_q : pc_q + 32'd4;
      retired_d = retired_q + 32'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      load_q      <= '0;
      retired_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      load_q      <= load_d;
      retired_q   <= retired_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign bus.stage            = state_q;
  assign bus.PC_value         = pc_q;
  assign bus.instr_reg        = instr_q;
  assign bus.load_data        = load_q;
  assign bus.retired_count    = retired_q;
  assign bus.halted           = (state_q == S_HALTED);
  assign bus.reg_write_enable = (state_q == S_REG_WRITE) && writes_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer. Two instances share one stimulus path:
// - dut_a: MEM_LATENCY=1, RESET_PC=FFFF_FFFC.
// - dut_b: MEM_LATENCY=3, RESET_PC=0.
// Only the selected instance comes out of reset.
// The driver plays instructions cycle by cycle from a timing model and
// pushes the expected retirement record.
// The monitor pops and checks a record on the cycle after each REG_WRITE.

`ifndef STAGE_SEQUENCER_DEFINES
`define STAGE_SEQUENCER_DEFINES
`define STAGE_WIDTH        3
`define STAGE_PC_UPDATE    3'd0
`define STAGE_INSTR_FETCH  3'd1
`define STAGE_DECODE       3'd2
`define STAGE_EXECUTE      3'd3
`define STAGE_MEMORY       3'd4
`define STAGE_REG_WRITE    3'd5
`define STAGE_HALTED       3'd6
`define INSTR_ALU          5'd0
`define INSTR_LOAD         5'd1
`define INSTR_STORE        5'd2
`define INSTR_BRANCH       5'd3
`define INSTR_JUMP         5'd4
`define INSTR_HALT         5'd5
`endif

module tb_stage_sequencer;

  localparam logic [31:0] RPC_A = 32'hFFFF_FFFC;
  localparam int          LAT_A = 1;
  localparam logic [31:0] RPC_B = 32'h0000_0000;
  localparam int          LAT_B = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] load;
    logic [31:0] retired;
    logic        rwe;
    logic [7:0]  latency;
  } exp_t;

  typedef enum logic [1:0] {M_RUN, M_RESET, M_PREHALT, M_HALT} mode_e;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        done = 1'b0;
  mode_e       chk_mode = M_RUN;

  logic [4:0]  instr_type = `INSTR_ALU;
  logic [31:0] mem_data = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;

  stage_sequencer_if ifa ();
  stage_sequencer_if ifb ();

  assign ifa.current_instr_type = instr_type;
  assign ifa.mem_read_data      = mem_data;
  assign ifa.branch_taken       = br_taken;
  assign ifa.branch_target      = br_target;
  assign ifb.current_instr_type = instr_type;
  assign ifb.mem_read_data      = mem_data;
  assign ifb.branch_taken       = br_taken;
  assign ifb.branch_target      = br_target;

  stage_sequencer #(.RESET_PC(RPC_A), .MEM_LATENCY(LAT_A)) dut_a (
    .clk (clk),
    .rst (sel ? 1'b1 : rst),
    .bus (ifa)
  );

  stage_sequencer #(.RESET_PC(RPC_B), .MEM_LATENCY(LAT_B)) dut_b (
    .clk (clk),
    .rst (sel ? rst : 1'b1),
    .bus (ifb)
  );

  logic [`STAGE_WIDTH-1:0] o_stage;
  logic [31:0] o_pc, o_instr, o_load, o_retired;
  logic        o_rwe, o_halted;

  assign o_stage   = sel ? ifb.stage            : ifa.stage;
  assign o_pc      = sel ? ifb.PC_value         : ifa.PC_value;
  assign o_instr   = sel ? ifb.instr_reg        : ifa.instr_reg;
  assign o_load    = sel ? ifb.load_data        : ifa.load_data;
  assign o_retired = sel ? ifb.retired_count    : ifa.retired_count;
  assign o_rwe     = sel ? ifb.reg_write_enable : ifa.reg_write_enable;
  assign o_halted  = sel ? ifb.halted           : ifa.halted;

  // ---------------- reference model state (driver-owned) ----------------
  int          lat = LAT_A;
  logic [31:0] rpc = RPC_A;
  logic [31:0] m_pc, m_instr, m_load, m_retired;
  exp_t        exp_q[$];
  logic [4:0]  drv_t;
  logic        drv_tk;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_mode  = M_RESET;
    m_pc      = rpc;
    m_instr   = '0;
    m_load    = '0;
    m_retired = '0;
    @(posedge clk); #1;
    chk_mode = M_RUN;
    rst      = 1'b0;
  endtask

  // Called at the start of the instruction's PC_UPDATE cycle.
  // If abort_c is not negative, rst is raised at that cycle and the
  // instruction never retires.
  task automatic run_instr(input logic [4:0] t, input logic [31:0] iw,
                           input logic [31:0] lw, input logic tk,
                           input logic [31:0] tg, input logic junk_br,
                           input int abort_c);
    int   mem_len;
    int   total;
    int   exec_c;
    int   mem_last;
    exp_t e;
    mem_len  = ((t == `INSTR_LOAD) || (t == `INSTR_STORE)) ? lat : 1;
    total    = lat + mem_len + 4;
    exec_c   = lat + 2;
    mem_last = lat + 2 + mem_len;
    m_pc      = tk ? tg : m_pc + 32'd4;
    m_retired = m_retired + 32'd1;
    m_instr   = iw;
    if (t == `INSTR_LOAD) m_load = lw;
    e.pc      = m_pc;
    e.instr   = iw;
    e.load    = m_load;
    e.retired = m_retired;
    e.rwe     = !((t == `INSTR_STORE) || (t == `INSTR_BRANCH) ||
                  (t == `INSTR_JUMP)  || (t == `INSTR_HALT));
    e.latency = 8'(total);
    if (abort_c < 0) exp_q.push_back(e);
    instr_type = t;
    for (int c = 0; c < total; c++) begin
      if (c == lat)           mem_data = iw;
      else if (c == mem_last) mem_data = lw;
      else                    mem_data = $urandom();
      if (c == exec_c) begin
        br_taken  = tk;
        br_target = tg;
      end else begin
        br_taken  = junk_br ? 1'($urandom_range(0, 1)) : 1'b0;
        br_target = $urandom();
      end
      if (c == abort_c) begin
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_halt(input logic [31:0] iw);
    instr_type = `INSTR_HALT;
    m_instr    = iw;
    for (int c = 0; c < lat + 2; c++) begin
      mem_data  = (c == lat) ? iw : $urandom();
      br_taken  = 1'($urandom_range(0, 1));
      br_target = $urandom();
      if (c == lat + 1) chk_mode = M_PREHALT;
      @(posedge clk); #1;
    end
    chk_mode = M_HALT;
    for (int k = 0; k < 21; k++) begin
      instr_type = 5'($urandom_range(0, 31));
      mem_data   = $urandom();
      br_taken   = 1'($urandom_range(0, 1));
      br_target  = $urandom();
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [4:0] pick_type(input int r);
    case (r)
      0:       return `INSTR_ALU;
      1:       return `INSTR_LOAD;
      2:       return `INSTR_STORE;
      3:       return `INSTR_BRANCH;
      4:       return `INSTR_JUMP;
      5:       return 5'd9;
      default: return 5'd20;
    endcase
  endfunction

  task automatic random_block(input int n);
    for (int i = 0; i < n; i++) begin
      drv_t  = pick_type(int'($urandom_range(0, 6)));
      drv_tk = ($urandom_range(0, 3) == 0);
      run_instr(drv_t, $urandom(), $urandom(), drv_tk,
                $urandom() & 32'hFFFF_FFFC, 1'b1, -1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Instance A: latency 1, reset PC at the top of the address space.
    do_reset();
    run_instr(`INSTR_ALU,    32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    run_instr(`INSTR_ALU,    32'h0BAD_F00D, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    run_instr(`INSTR_BRANCH, 32'h0000_0063, 32'h0, 1'b1, 32'h0000_0100, 1'b0, -1);
    run_instr(`INSTR_LOAD,   32'h0000_0003, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, -1);
    random_block(25);
    run_halt(32'h0000_007F);

    // Instance B: latency 3, reset PC zero.
    rst = 1'b1;
    sel = 1'b1;
    lat = LAT_B;
    rpc = RPC_B;
    do_reset();
    run_instr(`INSTR_ALU,   32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    run_instr(`INSTR_LOAD,  32'h0000_0083, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, -1);
    // Store cut off by reset in its second memory wait cycle.
    run_instr(`INSTR_STORE, 32'h0000_0023, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, LAT_B + 4);
    do_reset();
    run_instr(`INSTR_ALU,   32'hA5A5_0001, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    random_block(25);
    run_halt(32'h0000_00FF);
    done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat_cnt  = 0;
  int   rw_lat   = 0;
  logic prev_rw  = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else if (rst) begin
      lat_cnt = 0;
      prev_rw = 1'b0;
      if (chk_mode == M_RESET) begin
        check("rst_stage",   32'(o_stage), 32'(`STAGE_PC_UPDATE));
        check("rst_pc",      o_pc, rpc);
        check("rst_instr",   o_instr, 32'h0);
        check("rst_load",    o_load, 32'h0);
        check("rst_retired", o_retired, 32'h0);
        check("rst_rwe",     32'(o_rwe), 32'h0);
        check("rst_halted",  32'(o_halted), 32'h0);
        exp_q.delete();
      end
    end else begin
      if (prev_rw) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: actual=retire required=none at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pc",      o_pc, mon_e.pc);
          check("retired", o_retired, mon_e.retired);
          check("instr",   o_instr, mon_e.instr);
          check("load",    o_load, mon_e.load);
          check("latency", 32'(rw_lat), 32'(mon_e.latency));
        end
      end
      if ((lat_cnt == 0) || prev_rw) lat_cnt = 1;
      else                           lat_cnt = lat_cnt + 1;
      if (o_stage == `STAGE_REG_WRITE) begin
        rw_lat = lat_cnt;
        if (exp_q.size() != 0) check("rwe_in_rw", 32'(o_rwe), 32'(exp_q[0].rwe));
      end else begin
        check("rwe_idle", 32'(o_rwe), 32'h0);
      end
      case (chk_mode)
        M_RUN: check("halted_run", 32'(o_halted), 32'h0);
        M_PREHALT: begin
          check("decode_stage",  32'(o_stage), 32'(`STAGE_DECODE));
          check("decode_halted", 32'(o_halted), 32'h0);
        end
        M_HALT: begin
          check("halt_stage",   32'(o_stage), 32'(`STAGE_HALTED));
          check("halt_flag",    32'(o_halted), 32'h1);
          check("halt_pc",      o_pc, m_pc);
          check("halt_retired", o_retired, m_retired);
          check("halt_instr",   o_instr, m_instr);
        end
        default: ;
      endcase
      prev_rw = (o_stage == `STAGE_REG_WRITE);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
